// File: rtl/iob_fifo_dp_ctrl.sv
// Purpose : single-clock FIFO controller driving an external dual-port RAM (A = write, B = read).
// Latency : read data valid 1 cycle after an accepted read (r_valid); writes land in RAM on the accepting edge.
// Backpressure: writes refused while w_full, reads refused while r_empty; refused requests set sticky overflow/underflow.
//
// Ports:
//   clk, arst_n, clear            clock, async active-low reset, synchronous flush
//   w_en/w_data/w_full            write side
//   r_en/r_data/r_valid/r_empty   read side (r_data comes straight from ext_doutB)
//   almost_full/almost_empty      threshold flags from the registered level
//   level                         occupancy 0..2**ADDR_W
//   overflow/underflow            sticky error flags
//   ext_*                         RAM port A (write) and port B (read) controls
module iob_fifo_dp_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AFULL_TH  = 2**ADDR_W - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clear,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              r_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    output logic [DATA_W-1:0] ext_dinA,
    output logic [ADDR_W-1:0] ext_addrA,
    output logic              ext_enA,
    output logic              ext_weA,
    output logic [ADDR_W-1:0] ext_addrB,
    output logic              ext_enB,
    input  logic [DATA_W-1:0] ext_doutB
);

    localparam logic [ADDR_W:0]   DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AFULL_LVL  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AEMPTY_LVL = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   LVL_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              w_accept;
    logic              r_accept;
    logic [ADDR_W:0]   level_nxt;

    // Flags come only from the registered level: no fall-through, so a
    // read at level 0 is refused even if a write is accepted alongside it.
    assign w_full       = (level == DEPTH);
    assign r_empty      = (level == '0);
    assign almost_full  = (level >= AFULL_LVL);
    assign almost_empty = (level <= AEMPTY_LVL);

    // clear wins over any concurrent request.
    assign w_accept = w_en & ~w_full  & ~clear;
    assign r_accept = r_en & ~r_empty & ~clear;

    always_comb begin
        level_nxt = level;
        case ({w_accept, r_accept})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_accept) wptr <= wptr + PTR_ONE;
            if (r_accept) rptr <= rptr + PTR_ONE;
            level   <= level_nxt;
            r_valid <= r_accept;
            if (w_en && w_full)  overflow  <= 1'b1;
            if (r_en && r_empty) underflow <= 1'b1;
        end
    end

    // RAM side is purely combinational. wptr==rptr only when empty or full,
    // so port A and port B never touch the same address in one cycle.
    assign ext_dinA  = w_data;
    assign ext_addrA = wptr;
    assign ext_enA   = w_accept;
    assign ext_weA   = w_accept;
    assign ext_addrB = rptr;
    assign ext_enB   = r_accept;
    assign r_data    = ext_doutB;

endmodule

// File: tb/tb_iob_fifo_dp_ctrl.sv
// Purpose : directed self-checking bench for iob_fifo_dp_ctrl with a depth-4 RAM model.
// Latency : checks sampled 1 time unit after the rising edge.
// Backpressure: exercises full/empty refusal, clear and asynchronous reset.
module tb_iob_fifo_dp_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              clear;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic [DATA_W-1:0] ext_dinA;
    logic [ADDR_W-1:0] ext_addrA;
    logic              ext_enA;
    logic              ext_weA;
    logic [ADDR_W-1:0] ext_addrB;
    logic              ext_enB;
    logic [DATA_W-1:0] ext_doutB;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iob_fifo_dp_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_TH (3),
        .AEMPTY_TH(1)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .clear       (clear),
        .w_en        (w_en),
        .w_data      (w_data),
        .w_full      (w_full),
        .r_en        (r_en),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .r_empty     (r_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .ext_dinA    (ext_dinA),
        .ext_addrA   (ext_addrA),
        .ext_enA     (ext_enA),
        .ext_weA     (ext_weA),
        .ext_addrB   (ext_addrB),
        .ext_enB     (ext_enB),
        .ext_doutB   (ext_doutB)
    );

    // Dual-port RAM model: port A writes, port B registered read.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ext_enA && ext_weA) mem[ext_addrA] <= ext_dinA;
        if (ext_enB) ext_doutB <= mem[ext_addrB];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests, then return 1 unit after the edge with inputs idle.
    task automatic cycle(input logic we, input logic [DATA_W-1:0] wd,
                         input logic re, input logic cl);
        w_en   = we;
        w_data = wd;
        r_en   = re;
        clear  = cl;
        @(posedge clk);
        #1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0;
        clear  = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = '0;
        #12;
        check("rst_level",   32'(level),        32'd0);
        check("rst_empty",   32'(r_empty),      32'd1);
        check("rst_full",    32'(w_full),       32'd0);
        check("rst_aempty",  32'(almost_empty), 32'd1);
        check("rst_afull",   32'(almost_full),  32'd0);
        check("rst_rvalid",  32'(r_valid),      32'd0);
        check("rst_ovf",     32'(overflow),     32'd0);
        check("rst_unf",     32'(underflow),    32'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill 0x11..0x44 with level and threshold flags at each step.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        check("fill1_level",  32'(level), 32'd1);
        check("fill1_aempty", 32'(almost_empty), 32'd1);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        check("fill2_level",  32'(level), 32'd2);
        check("fill2_aempty", 32'(almost_empty), 32'd0);
        check("fill2_afull",  32'(almost_full), 32'd0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        check("fill3_level",  32'(level), 32'd3);
        check("fill3_afull",  32'(almost_full), 32'd1);
        check("fill3_full",   32'(w_full), 32'd0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        check("fill4_level",  32'(level), 32'd4);
        check("fill4_full",   32'(w_full), 32'd1);

        // Write while full: refused, overflow sticks.
        w_en = 1'b1; w_data = 8'h55;
        #1;
        check("ovf_enA", 32'(ext_enA), 32'd0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);

        // Drain returns exactly 0x11..0x44.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_valid", 32'(r_valid), 32'd1);
            check("drain_data",  32'(r_data),  32'(8'h11 * (i + 1)));
            check("drain_level", 32'(level),   32'(3 - i));
        end
        check("drain_empty", 32'(r_empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_rvalid", 32'(r_valid), 32'd0);

        // Read while empty: refused, underflow sticks.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_flag",   32'(underflow), 32'd1);
        check("unf_rvalid", 32'(r_valid),   32'd0);

        // Simultaneous at level 0: only the write goes.
        w_en = 1'b1; r_en = 1'b1; w_data = 8'h66;
        #1;
        check("sim0_enB", 32'(ext_enB), 32'd0);
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        check("sim0_level",  32'(level),   32'd1);
        check("sim0_rvalid", 32'(r_valid), 32'd0);

        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        // Simultaneous at level 2: both go.
        cycle(1'b1, 8'h88, 1'b1, 1'b0);
        check("sim2_level", 32'(level),   32'd2);
        check("sim2_valid", 32'(r_valid), 32'd1);
        check("sim2_data",  32'(r_data),  32'h66);

        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("pre_sim4_level", 32'(level), 32'd4);
        // Simultaneous at level 4: only the read goes.
        cycle(1'b1, 8'hBB, 1'b1, 1'b0);
        check("sim4_level", 32'(level),  32'd3);
        check("sim4_data",  32'(r_data), 32'h77);

        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("post4_d0", 32'(r_data), 32'h88);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("post4_d1", 32'(r_data), 32'h99);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("post4_d2", 32'(r_data), 32'hAA);
        check("post4_empty", 32'(r_empty), 32'd1);

        // Wrap-around at steady level 1: outputs 0..9 in order.
        cycle(1'b1, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i + 1), 1'b1, 1'b0);
            check("wrap_valid", 32'(r_valid), 32'd1);
            check("wrap_data",  32'(r_data),  32'(i));
            check("wrap_level", 32'(level),   32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_last", 32'(r_data), 32'd10);
        check("wrap_empty", 32'(r_empty), 32'd1);

        // Clear at level 3 with overflow set, alongside a write.
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        check("preclr_level", 32'(level),    32'd3);
        check("preclr_ovf",   32'(overflow), 32'd1);
        clear = 1'b1; w_en = 1'b1; w_data = 8'hC4;
        #1;
        check("clr_enA", 32'(ext_enA), 32'd0);
        cycle(1'b1, 8'hC4, 1'b0, 1'b1);
        check("clr_level", 32'(level),     32'd0);
        check("clr_empty", 32'(r_empty),   32'd1);
        check("clr_ovf",   32'(overflow),  32'd0);
        check("clr_unf",   32'(underflow), 32'd0);
        check("clr_addrA", 32'(ext_addrA), 32'd0);

        // Asynchronous reset between edges.
        cycle(1'b1, 8'hD1, 1'b0, 1'b0);
        cycle(1'b1, 8'hD2, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("prearst_valid", 32'(r_valid), 32'd1);
        check("prearst_level", 32'(level),   32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check("arst_level",  32'(level),     32'd0);
        check("arst_valid",  32'(r_valid),   32'd0);
        check("arst_empty",  32'(r_empty),   32'd1);
        check("arst_addrB",  32'(ext_addrB), 32'd0);
        #10;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_fifo_dp_ctrl.md
Name: iob_fifo_dp_ctrl

Overview:
- Synchronous single-clock FIFO controller that drives an external dual-port RAM (iob_ram_dp) directly upstream of it.
- Port A of the RAM is used only for writes and port B only for reads; this block owns the pointers, occupancy level, flags and read-data valid tracking.
- Used wherever Versat-side streams need elastic buffering backed by the shared dual-port RAM macro.

Parameters:
- DATA_W, 8, word width; must equal the RAM DATA_W.
- ADDR_W, 6, RAM address width; FIFO depth is 2**ADDR_W.
- AFULL_TH, 2**ADDR_W-1, almost_full asserts when level >= AFULL_TH.
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of FIFO contents.
- w_en  in  1  write request.
- w_data  in  DATA_W  write data.
- w_full  out  1  FIFO full.
- r_en  in  1  read request.
- r_data  out  DATA_W  read data; wired from ext_doutB.
- r_valid  out  1  r_data holds the word popped in the previous cycle.
- r_empty  out  1  FIFO empty.
- almost_full  out  1  level >= AFULL_TH.
- almost_empty  out  1  level <= AEMPTY_TH.
- level  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- ext_dinA  out  DATA_W  RAM port A data; equals w_data.
- ext_addrA  out  ADDR_W  RAM port A address; equals wptr.
- ext_enA  out  1  RAM port A enable; equals w_accept.
- ext_weA  out  1  RAM port A write enable; equals w_accept.
- ext_addrB  out  ADDR_W  RAM port B address; equals rptr.
- ext_enB  out  1  RAM port B enable; equals r_accept.
- ext_doutB  in  DATA_W  RAM port B registered read data.
- The RAM-side data and address outputs are combinational; ext_dinB and ext_weB are tied off by the integrator: ext_weB=0, ext_dinB=0.

Behaviour:
- Reset: asynchronous, active-low (arst_n=0). Effects:
  - wptr=0, rptr=0, level=0, r_valid=0, overflow=0, underflow=0.
  - Outputs during reset: r_empty=1, w_full=0, almost_empty=1 (AEMPTY_TH>=0), almost_full=0 (unless AFULL_TH=0).
  - Reset may assert mid-operation; all contents are logically discarded.
- Acceptance:
  - w_accept = w_en & ~w_full.
  - r_accept = r_en & ~r_empty.
  - Flags are evaluated from the current registered level only. A write when full is rejected even if a read is accepted in the same cycle. A read when empty is rejected even if a write is accepted in the same cycle. No fall-through path.
- Pointers:
  - ADDR_W bits each, wrap naturally from 2**ADDR_W-1 to 0.
  - wptr increments on w_accept; rptr increments on r_accept.
- Level update:
  - +1 on a write-only cycle; -1 on a read-only cycle; unchanged when both or neither are accepted.
  - w_full = (level == 2**ADDR_W); r_empty = (level == 0).
- Address conflicts: the same RAM address is never written and read in one cycle, because wptr==rptr implies either empty (read rejected) or full (write rejected).
- Read latency: 1 cycle.
  - r_valid is a register that takes r_accept on every edge.
  - r_data = ext_doutB is meaningful only while r_valid=1; ext_doutB may change on cycles without a read.
  - Back-to-back reads give one word per cycle.
- Sticky errors:
  - overflow is set by w_en & w_full; underflow is set by r_en & r_empty.
  - Both are cleared only by arst_n or clear.
- clear (synchronous):
  - Next edge: wptr=0, rptr=0, level=0, r_valid=0, overflow=0, underflow=0.
  - clear has priority over any concurrent w_en or r_en; those requests are not accepted, ext_enA=0 and ext_enB=0.
- No internal storage of data words; the RAM holds all data.

Test Plan:
- Depth-4 fill then drain (ADDR_W=2, DATA_W=8):
  - Write 0x11, 0x22, 0x33, 0x44 -> level 1,2,3,4; w_full=1 after the 4th write.
  - Then read 4 times -> r_valid 1 cycle after each pop with r_data 0x11, 0x22, 0x33, 0x44; r_empty=1 and level=0 at the end.
- Overflow and underflow:
  - When full, write 0x55 -> not accepted (ext_enA=0), level stays 4, overflow=1; draining returns 0x11..0x44 only.
  - Read when empty -> underflow=1, r_valid stays 0.
- Simultaneous requests:
  - At level 2, w_en and r_en together -> both accepted, level stays 2.
  - At level 0 -> only the write is accepted, level=1, r_valid=0 next cycle.
  - At level 4 -> only the read is accepted, level=3.
- Wrap-around: 10 write/read pairs with data 0..9 at steady level 1 -> output order is 0..9 and pointers wrap past 3 with no corruption.
- Thresholds (AFULL_TH=3, AEMPTY_TH=1):
  - almost_full rises at the 3rd write.
  - almost_empty is 1 at levels 0..1 and 0 at level 2.
- Clear and reset:
  - At level 3 with overflow=1, pulse clear together with w_en -> level=0, r_empty=1, overflow=0, ext_enA=0.
  - Drop arst_n mid-stream between clock edges -> outputs take their reset values immediately, without waiting for a clock edge.
